uop_stream_block: RTL and testbench

Elastic, runtime-configurable successor to the fixed micro-op chain: a LEN-slot chain of `microop_unit` ALUs with valid/ready flow control, per-transaction shift amount, and registers at the slots selected by FF_MASK. Slot opcodes and immediates are loadable at run time through a config port while the chain is idle. It sits between the instruction-stream front end and the writeback mux of each custom-core datapath lane.

---
 rtl/uop_pkg.sv | 39 +++
 rtl/microop_unit_dyn.sv | 34 +++
 rtl/uop_pipe_reg.sv | 61 ++++++
 rtl/uop_stream_block.sv | 138 +++++++++++++
 tb/tb_uop_stream_block.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uop_pkg.sv
`default_nettype none
// =====================================================================
// uop_pkg : shared opcode, config-entry types and mask helper for uop_stream_block
// Rev 1.0
// =====================================================================
package uop_pkg;

   localparam int OPW   = 3;
   localparam int IMM_W = 32;

   // OP_NOP must stay encoded as zero: an all-zero OPS parameter means "all NOP"
   typedef enum logic [OPW-1:0] {
      OP_NOP = 3'd0,
      OP_ADD = 3'd1,
      OP_SUB = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } op_t;

   typedef struct packed {
      op_t              op;
      logic [IMM_W-1:0] imm;
      logic             use_imm;
   } cfg_entry_t;

   function automatic int popcount_mask(input logic [31:0] mask, input int len);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         if ((i < len) && mask[i]) cnt++;
      end
      return cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/microop_unit_dyn.sv
`default_nettype none
// =====================================================================
// microop_unit_dyn : single-slot ALU with the opcode supplied as a port
// Rev 1.0
// =====================================================================
module microop_unit_dyn
   import uop_pkg::*;
#(
   parameter int W   = 32,
   parameter int SHW = 5
) (
   input  op_t            op_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   input  logic [SHW-1:0] shamt_i,
   output logic [W-1:0]   y_o
);

   always_comb begin
      y_o = a_i;
      case (op_i)
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_SHL:  y_o = a_i << shamt_i;
         OP_SHR:  y_o = a_i >> shamt_i;
         default: y_o = a_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/uop_pipe_reg.sv
`default_nettype none
// =====================================================================
// uop_pipe_reg : elastic data/shamt/valid register with ready chaining
// Rev 1.0
// =====================================================================
module uop_pipe_reg #(
   parameter int W   = 32,
   parameter int SHW = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic [W-1:0]   in_data_i,
   input  logic [SHW-1:0] in_shamt_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [W-1:0]   out_data_o,
   output logic [SHW-1:0] out_shamt_o
);

   logic           valid_q, valid_d;
   logic [W-1:0]   data_q, data_d;
   logic [SHW-1:0] shamt_q, shamt_d;
   logic           w_load;

   // A full register still accepts when downstream drains in the same cycle
   assign in_ready_o = !valid_q || out_ready_i;
   assign w_load     = in_valid_i && in_ready_o;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      shamt_d = shamt_q;
      if (w_load) begin
         valid_d = 1'b1;
         data_d  = in_data_i;
         shamt_d = in_shamt_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         shamt_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         shamt_q <= shamt_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_shamt_o = shamt_q;

endmodule
`default_nettype wire

// File: rtl/uop_stream_block.sv
`default_nettype none
// =====================================================================
// uop_stream_block : elastic LEN-slot micro-op chain with runtime slot config
// Rev 1.0
// =====================================================================
module uop_stream_block
   import uop_pkg::*;
#(
   parameter int                         LEN     = 4,
   parameter int                         W       = 32,
   parameter logic [31:0]                FF_MASK = 32'h0,
   parameter logic [LEN-1:0][OPW-1:0]    OPS     = '0,
   parameter logic [LEN-1:0][IMM_W-1:0]  IMM     = '0,
   parameter logic [LEN-1:0]             USE_IMM = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     src_valid,
   output logic                     src_ready,
   input  logic [W-1:0]             src_data,
   input  logic [$clog2(W)-1:0]     src_shamt,
   output logic                     dst_valid,
   input  logic                     dst_ready,
   output logic [W-1:0]             dst_data,
   input  logic                     cfg_we,
   input  logic [$clog2(LEN):0]     cfg_idx,
   input  op_t                      cfg_op,
   input  logic [W-1:0]             cfg_imm,
   input  logic                     cfg_use_imm,
   output logic                     cfg_err,
   output logic                     busy
);

   localparam int              SHW   = $clog2(W);
   localparam int              IDXW  = $clog2(LEN) + 1;
   localparam int              N     = popcount_mask(FF_MASK, LEN);
   localparam logic [IDXW-1:0] C_LEN = IDXW'(LEN);

   cfg_entry_t [LEN-1:0] cfg_q, cfg_d;
   logic                 cfg_err_q, cfg_err_d;
   logic                 w_cfg_accept;
   logic [LEN-1:0]       w_reg_valid;

   assign busy         = (N == 0) ? 1'b0 : (|w_reg_valid);
   assign w_cfg_accept = cfg_we && (cfg_idx < C_LEN) && !busy && !src_valid;

   always_comb begin
      cfg_d     = cfg_q;
      cfg_err_d = cfg_we && !w_cfg_accept;
      for (int k = 0; k < LEN; k++) begin
         if (w_cfg_accept && (cfg_idx == IDXW'(k))) begin
            cfg_d[k] = '{op: cfg_op, imm: IMM_W'(cfg_imm), use_imm: cfg_use_imm};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LEN; k++) begin
            cfg_q[k] <= '{op: op_t'(OPS[k]), imm: IMM[k], use_imm: USE_IMM[k]};
         end
         cfg_err_q <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   // Each slot links to its neighbours by scope so the forward data path and
   // the backward ready path never share one vector.
   for (genvar i = 0; i < LEN; i++) begin : g_slot
      logic [W-1:0]   w_a, w_b, w_y, w_out_data;
      logic [SHW-1:0] w_shamt, w_out_shamt;
      logic           w_valid, w_out_valid, w_in_ready, w_out_ready;

      if (i == 0) begin : g_head
         assign w_a     = src_data;
         assign w_shamt = src_shamt;
         assign w_valid = src_valid;
      end else begin : g_link
         assign w_a     = g_slot[i-1].w_out_data;
         assign w_shamt = g_slot[i-1].w_out_shamt;
         assign w_valid = g_slot[i-1].w_out_valid;
      end

      if (i == LEN - 1) begin : g_tail
         assign w_out_ready = dst_ready;
      end else begin : g_next
         assign w_out_ready = g_slot[i+1].w_in_ready;
      end

      assign w_b = cfg_q[i].use_imm ? W'(cfg_q[i].imm) : w_a;

      microop_unit_dyn #(
         .W   (W),
         .SHW (SHW)
      ) u_alu (
         .op_i    (cfg_q[i].op),
         .a_i     (w_a),
         .b_i     (w_b),
         .shamt_i (w_shamt),
         .y_o     (w_y)
      );

      if (FF_MASK[i]) begin : g_reg
         uop_pipe_reg #(
            .W   (W),
            .SHW (SHW)
         ) u_reg (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (w_valid),
            .in_ready_o  (w_in_ready),
            .in_data_i   (w_y),
            .in_shamt_i  (w_shamt),
            .out_valid_o (w_out_valid),
            .out_ready_i (w_out_ready),
            .out_data_o  (w_out_data),
            .out_shamt_o (w_out_shamt)
         );
         assign w_reg_valid[i] = w_out_valid;
      end else begin : g_pass
         assign w_out_data     = w_y;
         assign w_out_shamt    = w_shamt;
         assign w_out_valid    = w_valid;
         assign w_in_ready     = w_out_ready;
         assign w_reg_valid[i] = 1'b0;
      end
   end

   assign src_ready = g_slot[0].w_in_ready;
   assign dst_valid = g_slot[LEN-1].w_out_valid;
   assign dst_data  = g_slot[LEN-1].w_out_data;

endmodule
`default_nettype wire

// File: tb/tb_uop_stream_block.sv
`default_nettype none
// =====================================================================
// tb_uop_stream_block : directed scoreboard bench for uop_stream_block
// Rev 1.0
// =====================================================================
module tb_uop_stream_block;
   import uop_pkg::*;

   logic clk, rst;

   // Registered chain (FF after slots 0 and 2)
   logic        a_src_valid, a_src_ready, a_dst_valid, a_dst_ready;
   logic [31:0] a_src_data, a_dst_data, a_cfg_imm;
   logic [4:0]  a_src_shamt;
   logic        a_cfg_we, a_cfg_use_imm, a_cfg_err, a_busy;
   logic [2:0]  a_cfg_idx;
   op_t         a_cfg_op;

   // Purely combinational chain
   logic        b_src_valid, b_src_ready, b_dst_valid, b_dst_ready;
   logic [31:0] b_src_data, b_dst_data, b_cfg_imm;
   logic [4:0]  b_src_shamt;
   logic        b_cfg_we, b_cfg_use_imm, b_cfg_err, b_busy;
   logic [2:0]  b_cfg_idx;
   op_t         b_cfg_op;

   int total = 0;
   int bad   = 0;
   int n_out = 0;
   int n_before, lat, beat, cyc, acc, acc_at_stall;

   logic [31:0] sb[$];
   op_t         m_op  [4];
   logic [31:0] m_imm [4];
   logic        m_use [4];

   uop_stream_block #(
      .LEN(4), .W(32), .FF_MASK(32'h5),
      .OPS({4{OP_ADD}}), .IMM('0), .USE_IMM('0)
   ) dut (
      .clk(clk), .rst(rst),
      .src_valid(a_src_valid), .src_ready(a_src_ready),
      .src_data(a_src_data), .src_shamt(a_src_shamt),
      .dst_valid(a_dst_valid), .dst_ready(a_dst_ready), .dst_data(a_dst_data),
      .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx), .cfg_op(a_cfg_op),
      .cfg_imm(a_cfg_imm), .cfg_use_imm(a_cfg_use_imm),
      .cfg_err(a_cfg_err), .busy(a_busy)
   );

   uop_stream_block #(
      .LEN(4), .W(32), .FF_MASK(32'h0),
      .OPS({4{OP_ADD}}), .IMM('0), .USE_IMM('0)
   ) dut_comb (
      .clk(clk), .rst(rst),
      .src_valid(b_src_valid), .src_ready(b_src_ready),
      .src_data(b_src_data), .src_shamt(b_src_shamt),
      .dst_valid(b_dst_valid), .dst_ready(b_dst_ready), .dst_data(b_dst_data),
      .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_op(b_cfg_op),
      .cfg_imm(b_cfg_imm), .cfg_use_imm(b_cfg_use_imm),
      .cfg_err(b_cfg_err), .busy(b_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic void tb_defaults();
      for (int i = 0; i < 4; i++) begin
         m_op[i]  = OP_ADD;
         m_imm[i] = 32'h0;
         m_use[i] = 1'b0;
      end
   endfunction

   // Reference chain: slot i computes op(a, use ? imm : a, shamt)
   function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] sh);
      logic [31:0] a, b, y;
      a = x;
      for (int i = 0; i < 4; i++) begin
         b = m_use[i] ? m_imm[i] : a;
         case (m_op[i])
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = a << sh;
            OP_SHR:  y = a >> sh;
            default: y = a;
         endcase
         a = y;
      end
      return a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor, sampled one time unit before each rising edge
   always begin
      logic [31:0] exp;
      @(negedge clk);
      #4;
      if (!rst) begin
         if (a_src_valid && a_src_ready) sb.push_back(model(a_src_data, a_src_shamt));
         if (a_dst_valid && a_dst_ready) begin
            exp = (sb.size() != 0) ? sb.pop_front() : {32{1'bx}};
            n_out++;
            check("sb_dst_data", a_dst_data, exp);
         end
      end
   end

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((sb.size() != 0 || a_busy) && n < 50) begin
         @(negedge clk);
         #4;
         n++;
      end
      check(tag, 32'(n < 50), 32'd1);
   endtask

   task automatic await_out(input string tag, input logic [31:0] exp);
      int n;
      n = 0;
      while (!a_dst_valid && n < 20) begin
         @(negedge clk);
         #4;
         n++;
      end
      check(tag, a_dst_valid ? a_dst_data : {32{1'bx}}, exp);
   endtask

   task automatic send_one(input logic [31:0] d, input logic [4:0] sh);
      @(negedge clk);
      a_src_valid = 1'b1; a_src_data = d; a_src_shamt = sh;
      #4;
      @(negedge clk);
      a_src_valid = 1'b0;
      #4;
   endtask

   initial begin
      rst = 1'b1;
      a_src_valid = 0; a_src_data = 0; a_src_shamt = 0; a_dst_ready = 1;
      a_cfg_we = 0; a_cfg_idx = 0; a_cfg_op = OP_NOP; a_cfg_imm = 0; a_cfg_use_imm = 0;
      b_src_valid = 0; b_src_data = 0; b_src_shamt = 0; b_dst_ready = 1;
      b_cfg_we = 0; b_cfg_idx = 0; b_cfg_op = OP_NOP; b_cfg_imm = 0; b_cfg_use_imm = 0;
      tb_defaults();

      // Reset state
      repeat (2) @(negedge clk);
      #4;
      check("rst_dst_valid", 32'(a_dst_valid), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_cfg_err", 32'(a_cfg_err), 32'd0);
      check("rst_comb_busy", 32'(b_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #4;
      check("rst_src_ready", 32'(a_src_ready), 32'd1);

      // Combinational chain: same-cycle pass-through
      @(negedge clk);
      b_src_valid = 1; b_src_data = 32'd5;
      #4;
      check("comb_valid", 32'(b_dst_valid), 32'd1);
      check("comb_data", b_dst_data, 32'd80);
      @(negedge clk);
      b_dst_ready = 0; b_src_data = 32'd6;
      b_cfg_we = 1; b_cfg_idx = 3'd0; b_cfg_op = OP_SUB;
      #4;
      check("comb_ready", 32'(b_src_ready), 32'd0);
      check("comb_data2", b_dst_data, model(32'd6, 5'd0));
      check("comb_busy", 32'(b_busy), 32'd0);
      @(negedge clk);
      b_src_valid = 0; b_cfg_we = 0; b_dst_ready = 1;
      #4;
      check("comb_cfg_err", 32'(b_cfg_err), 32'd1);
      @(negedge clk);
      b_src_valid = 1; b_src_data = 32'd7;
      #4;
      check("comb_cfg_kept", b_dst_data, 32'd112);
      @(negedge clk);
      b_src_valid = 0;

      // Single beat, latency 2
      @(negedge clk);
      a_src_valid = 1; a_src_data = 32'd3; a_src_shamt = 0;
      #4;
      check("t1_src_ready", 32'(a_src_ready), 32'd1);
      @(negedge clk);
      a_src_valid = 0;
      lat = 1;
      #4;
      while (!a_dst_valid && lat < 10) begin
         @(negedge clk);
         #4;
         lat++;
      end
      check("t1_latency", 32'(lat), 32'd2);
      check("t1_data", a_dst_data, 32'd48);
      wait_drain("t1_drain");

      // Back-pressure: beats 1..8, dst_ready low for the first 5 cycles
      n_before = n_out;
      beat = 1; cyc = 0; acc = 0; acc_at_stall = -1;
      @(negedge clk);
      while (beat <= 8 && cyc < 60) begin
         a_dst_ready = (cyc >= 5);
         a_src_valid = 1; a_src_data = 32'(beat);
         #4;
         if (a_src_ready) begin
            beat++;
            acc++;
         end else if (acc_at_stall < 0) begin
            acc_at_stall = acc;
         end
         if (cyc >= 2 && cyc < 5) begin
            check("t2_hold_valid", 32'(a_dst_valid), 32'd1);
            check("t2_hold_data", a_dst_data, 32'd16);
         end
         @(negedge clk);
         cyc++;
      end
      a_src_valid = 0; a_dst_ready = 1;
      #4;
      check("t2_accept_before_stall", 32'(acc_at_stall), 32'd2);
      wait_drain("t2_drain");
      check("t2_out_count", 32'(n_out - n_before), 32'd8);

      // Runtime config: slot1 XOR 0xFF with imm, slot3 SHL
      @(negedge clk);
      a_cfg_we = 1; a_cfg_idx = 3'd1; a_cfg_op = OP_XOR; a_cfg_imm = 32'hFF; a_cfg_use_imm = 1;
      m_op[1] = OP_XOR; m_imm[1] = 32'hFF; m_use[1] = 1'b1;
      @(negedge clk);
      a_cfg_idx = 3'd3; a_cfg_op = OP_SHL; a_cfg_imm = 32'h0; a_cfg_use_imm = 0;
      m_op[3] = OP_SHL;
      #4;
      check("t3_cfg_ok1", 32'(a_cfg_err), 32'd0);
      @(negedge clk);
      a_cfg_we = 0;
      #4;
      check("t3_cfg_ok2", 32'(a_cfg_err), 32'd0);
      send_one(32'h0F, 5'd3);
      await_out("t3_data", 32'h0000_0E10);
      wait_drain("t3_drain");
      @(negedge clk);
      a_src_valid = 1; a_src_data = 32'h10; a_src_shamt = 5'd1;
      @(negedge clk);
      a_src_data = 32'h3; a_src_shamt = 5'd31;
      @(negedge clk);
      a_src_data = 32'hDEAD_BEEF; a_src_shamt = 5'd7;
      @(negedge clk);
      a_src_valid = 0;
      wait_drain("t3_stream_drain");

      // Write while busy is rejected
      @(negedge clk);
      a_src_valid = 1; a_src_data = 32'd7; a_src_shamt = 5'd2;
      @(negedge clk);
      a_src_valid = 0;
      a_cfg_we = 1; a_cfg_idx = 3'd1; a_cfg_op = OP_AND; a_cfg_imm = 32'h0; a_cfg_use_imm = 1;
      #4;
      check("t4_busy", 32'(a_busy), 32'd1);
      @(negedge clk);
      a_cfg_we = 0;
      #4;
      check("t4_err_busy", 32'(a_cfg_err), 32'd1);
      @(negedge clk);
      #4;
      check("t4_err_pulse", 32'(a_cfg_err), 32'd0);
      wait_drain("t4_drain");
      send_one(32'h0F, 5'd3);
      await_out("t4_old_op", 32'h0000_0E10);
      wait_drain("t4_drain2");

      // Write in the same cycle as a src beat is rejected
      @(negedge clk);
      a_src_valid = 1; a_src_data = 32'h0F; a_src_shamt = 5'd3;
      a_cfg_we = 1; a_cfg_idx = 3'd2; a_cfg_op = OP_SUB; a_cfg_use_imm = 0;
      @(negedge clk);
      a_src_valid = 0; a_cfg_we = 0;
      #4;
      check("t4b_err_same_cycle", 32'(a_cfg_err), 32'd1);
      await_out("t4b_old_op", 32'h0000_0E10);
      wait_drain("t4b_drain");

      // Out-of-range index
      @(negedge clk);
      a_cfg_we = 1; a_cfg_idx = 3'd4; a_cfg_op = OP_SUB;
      @(negedge clk);
      a_cfg_we = 0;
      #4;
      check("t5_err_idx", 32'(a_cfg_err), 32'd1);
      send_one(32'h0F, 5'd3);
      await_out("t5_unchanged", 32'h0000_0E10);
      wait_drain("t5_drain");

      // Reset with two beats in flight
      @(negedge clk);
      a_dst_ready = 0;
      a_src_valid = 1; a_src_data = 32'd1; a_src_shamt = 0;
      @(negedge clk);
      a_src_data = 32'd2;
      @(negedge clk);
      a_src_valid = 0;
      #4;
      check("t6_busy_before", 32'(a_busy), 32'd1);
      check("t6_valid_before", 32'(a_dst_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      tb_defaults();
      #4;
      check("t6_rst_dst_valid", 32'(a_dst_valid), 32'd0);
      check("t6_rst_busy", 32'(a_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      a_dst_ready = 1;
      send_one(32'd3, 5'd0);
      await_out("t6_cfg_reverted", 32'd48);
      wait_drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
